// File: rtl/mips_pkg.sv
// mips_pkg: MIPS memory opcodes, LSU state encoding and opcode classification helpers.
package mips_pkg;

    localparam logic [5:0] LB       = 6'h20;
    localparam logic [5:0] LH       = 6'h21;
    localparam logic [5:0] LW       = 6'h23;
    localparam logic [5:0] LBU      = 6'h24;
    localparam logic [5:0] LHU      = 6'h25;
    localparam logic [5:0] SB       = 6'h28;
    localparam logic [5:0] SH       = 6'h29;
    localparam logic [5:0] SW       = 6'h2B;
    localparam logic [5:0] MEM_IDLE = 6'h00;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_RD,
        STORE,
        RESP
    } lsu_state_t;

    function automatic logic op_known(input logic [5:0] op);
        return op inside {LB, LH, LW, LBU, LHU, SB, SH, SW};
    endfunction

    function automatic logic op_is_load(input logic [5:0] op);
        return op inside {LB, LH, LW, LBU, LHU};
    endfunction

    function automatic logic misaligned(input logic [5:0] op, input logic [1:0] off);
        return (op inside {LH, LHU, SH} && off[0]) || (op inside {LW, SW} && off != 2'b00);
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: byte/half lane extraction with extension for loads, and lane merge for sub-word stores.
module lsu_lane_align
    import mips_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic [5:0]  op_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] ldata_o,
    output logic [31:0] mword_o
);

    logic [4:0]  bsh;
    logic [4:0]  hsh;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] bmask;
    logic [31:0] hmask;

    // Big-endian puts offset 0 in the top lane, so the shift counts down from the MSB.
    assign bsh   = {BIG_ENDIAN ? ~off_i : off_i, 3'b000};
    assign hsh   = {BIG_ENDIAN ? ~off_i[1] : off_i[1], 4'b0000};
    assign b     = 8'(word_i >> bsh);
    assign h     = 16'(word_i >> hsh);
    assign bmask = 32'h0000_00FF << bsh;
    assign hmask = 32'h0000_FFFF << hsh;

    assign ldata_o = op_i == LB  ? {{24{b[7]}}, b} :
                     op_i == LBU ? {24'h0, b} :
                     op_i == LH  ? {{16{h[15]}}, h} :
                     op_i == LHU ? {16'h0, h} :
                     op_i == LW  ? word_i : 32'h0;

    assign mword_o = op_i == SB ? (word_i & ~bmask) | ({24'h0, wdata_i[7:0]} << bsh) :
                     op_i == SH ? (word_i & ~hmask) | ({16'h0, wdata_i[15:0]} << hsh) :
                     op_i == SW ? wdata_i : word_i;

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit driving a word-only data memory; adds sub-word loads
// and read-modify-write sub-word stores, reporting alignment/range errors.
module lsu_ctrl
    import mips_pkg::*;
#(
    parameter int MEM_WORDS  = 1024,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [5:0]  mem_op,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    lsu_state_t  state_q, state_d;
    logic [5:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] sdata_q, sdata_d;
    logic [31:0] word_q, word_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] ldata;
    logic [31:0] mword;
    logic        acc_err;

    lsu_lane_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_align (
        .op_i    (op_q),
        .off_i   (addr_q[1:0]),
        .word_i  (mem_rdata),
        .wdata_i (sdata_q),
        .ldata_o (ldata),
        .mword_o (mword)
    );

    assign acc_err = !op_known(req_op) || misaligned(req_op, req_addr[1:0]) ||
                     (req_addr >> 2) >= 32'(MEM_WORDS);

    // rdata/err are only rewritten on entry to RESP so the result holds until the next response.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        sdata_d = sdata_q;
        word_d  = word_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (req_valid) begin
                op_d    = req_op;
                addr_d  = req_addr;
                sdata_d = req_wdata;
                if (acc_err) begin
                    state_d = RESP;
                    rdata_d = 32'h0;
                    err_d   = 1'b1;
                end else if (op_is_load(req_op)) begin
                    state_d = LOAD;
                end else if (req_op == SW) begin
                    state_d = STORE;
                    word_d  = req_wdata;
                end else begin
                    state_d = RMW_RD;
                end
            end
            LOAD: begin
                rdata_d = ldata;
                err_d   = 1'b0;
                state_d = RESP;
            end
            RMW_RD: begin
                word_d  = mword;
                state_d = STORE;
            end
            STORE: begin
                rdata_d = 32'h0;
                err_d   = 1'b0;
                state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            op_q    <= MEM_IDLE;
            addr_q  <= 32'h0;
            sdata_q <= 32'h0;
            word_q  <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            sdata_q <= sdata_d;
            word_q  <= word_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready  = state_q == IDLE;
    assign resp_valid = state_q == RESP;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign mem_op     = (state_q == LOAD || state_q == RMW_RD) ? LW : state_q == STORE ? SW : MEM_IDLE;
    assign mem_addr   = {addr_q[31:2], 2'b00};
    assign mem_wdata  = word_q;

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store unit: the initiator side of the data-memory port.
- Accepts one MIPS memory instruction at a time from the pipeline and issues word-granular requests on the data-memory port (op, byte address, write value, combinational read value; write commits on posedge).
- Memory supports only LW/SW, so the unit provides LB/LBU/LH/LHU extraction and SB/SH read-modify-write.
- Reports result or alignment/range error back to the pipeline.

Parameters:
MEM_WORDS, 1024, depth of the data memory in 32-bit words; word index >= MEM_WORDS is an error.
BIG_ENDIAN, 1, 1 = byte offset 0 is bits [31:24] (MIPS); 0 = byte offset 0 is bits [7:0].

Ports:
clock  in  1  system clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
req_valid  in  1  pipeline presents a memory instruction.
req_ready  out  1  unit idle and able to accept.
req_op  in  6  MIPS opcode (LB, LH, LW, LBU, LHU, SB, SH, SW).
req_addr  in  32  effective byte address.
req_wdata  in  32  store data; byte/half taken from the low bits.
resp_valid  out  1  one-cycle pulse, result available.
resp_rdata  out  32  extended load result; 0 for stores/errors.
resp_err  out  1  misaligned, out-of-range or unsupported op (qualified by resp_valid).
mem_op  out  6  LW to read, SW to write, 0 = idle.
mem_addr  out  32  word-aligned byte address {addr[31:2],2'b00}.
mem_wdata  out  32  word to write.
mem_rdata  in  32  combinational read word from memory.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE.
  - req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_op=0, mem_addr=0, mem_wdata=0.
  - All outputs change immediately, so an in-flight RMW is abandoned before the SW cycle and memory is unchanged.
- FSM states: IDLE, LOAD, RMW_RD, STORE, RESP.
- IDLE:
  - req_ready=1; mem_op=0.
  - On req_valid, latch op/addr/wdata.
  - Error check on accept:
    - LH/LHU/SH with addr[0]!=0.
    - LW/SW with addr[1:0]!=0.
    - (addr>>2) >= MEM_WORDS.
    - Opcode not in set.
  - Error -> RESP with resp_err=1; no memory request is ever driven.
  - Otherwise: loads -> LOAD; SW -> STORE (mem_wdata=req_wdata); SB/SH -> RMW_RD.
- LOAD:
  - mem_op=LW.
  - Register the extracted lane from mem_rdata: zero-extended for LBU/LHU, sign-extended for LB/LH, full word for LW.
  - -> RESP.
- RMW_RD:
  - mem_op=LW.
  - Register the merged word: mem_rdata with the addressed lane replaced by wdata[7:0] (SB) or wdata[15:0] (SH); other lanes unchanged.
  - -> STORE.
- STORE:
  - mem_op=SW, mem_wdata=registered word.
  - Write commits on the posedge ending this cycle. -> RESP.
- RESP:
  - resp_valid=1 for exactly one cycle, req_ready=0. -> IDLE.
  - No response backpressure.
- Latency after accepting edge:
  - error: resp_valid in cycle 1.
  - loads and SW: cycle 2.
  - SB/SH: cycle 3.
- Throughput: a new request is accepted in the IDLE cycle following RESP.
- req_ready=0 outside IDLE; req_valid there is ignored and the request must be held.
- Lane mapping with BIG_ENDIAN=1:
  - byte offset k -> bits [31-8k -: 8].
  - half offset 0 -> [31:16], offset 2 -> [15:0].
- mem_addr always has bits [1:0]=0. mem_wdata holds its value when mem_op != SW.
- resp_rdata holds until the next RESP.

Decomposition:
- Shared package mips_pkg: opcode constants LB=6'h20, LH=6'h21, LW=6'h23, LBU=6'h24, LHU=6'h25, SB=6'h28, SH=6'h29, SW=6'h2B, MEM_IDLE=6'h00; FSM state enum.
- Sub-module lsu_lane_align (combinational): given op, addr[1:0], word and store data, produces the extended load value and the merged store word.
- lsu_lane_align is parameterised by BIG_ENDIAN and unit-testable alone.

Test Plan:
- Memory word 0x40 = 0x8899AABB; LB addr 0x41 -> cycle 2 resp_rdata=0xFFFFFF99, resp_err=0; LBU addr 0x41 -> 0x00000099.
- LH 0x42 on the same word -> 0xFFFFAABB; LHU 0x40 -> 0x00008899.
- SB addr 0x43 wdata 0x123456CC on word 0x11223344 -> mem SW in cycle 2 with 0x112233CC, resp in cycle 3; readback LW -> 0x112233CC.
- SH addr 0x41 -> resp_err=1 in cycle 1, mem_op stays 0 throughout; LW addr 0x1000 (MEM_WORDS=1024) -> resp_err=1.
- Back-to-back: SW 0xDEADBEEF to 0x8, then LW 0x8 held valid -> accepted in the IDLE cycle after RESP, returns 0xDEADBEEF.
- Assert reset_n=0 during RMW_RD of SB -> mem_op=0 immediately, no SW issued, target word unchanged, req_ready=1 after release.
